// File: rtl/mc_control_pkg.sv
// Shared constants for the multi-cycle MIPS control unit: opcodes, funct codes,
// ALU operation codes, mux select codes and the controller state encoding.
package mc_control_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  localparam logic [3:0] ALU_ADD  = 4'b1010;
  localparam logic [3:0] ALU_ADDU = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b1110;
  localparam logic [3:0] ALU_SUBU = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_NOR  = 4'b1100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLTU = 4'b1111;

  localparam logic [1:0] SRCB_RT     = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] BR_NONE = 2'b00;
  localparam logic [1:0] BR_BEQ  = 2'b01;
  localparam logic [1:0] BR_BNE  = 2'b10;

  typedef enum logic [3:0] {
    StIdle   = 4'd0,
    StFetch  = 4'd1,
    StDecode = 4'd2,
    StExecR  = 4'd3,
    StExecI  = 4'd4,
    StAddr   = 4'd5,
    StMemRd  = 4'd6,
    StMemWr  = 4'd7,
    StWbAlu  = 4'd8,
    StWbMem  = 4'd9,
    StBranch = 4'd10,
    StJump   = 4'd11,
    StTrap   = 4'd12
  } state_e;

  // States that wait on the memory handshake and are guarded by the timeout.
  function automatic logic waits_on_mem(state_e s);
    return (s == StFetch) || (s == StMemRd) || (s == StMemWr);
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational ALU operation decode: R-type by funct, I-type by opcode, with a
// legal flag for any code that has no ALU meaning.
module alu_op_decode
  import mc_control_pkg::*;
(
  input  logic [5:0] op_i,
  input  logic [5:0] func_i,
  output logic [3:0] alu_cntl_o,
  output logic       legal_o
);

  always_comb begin
    alu_cntl_o = ALU_AND;
    legal_o    = 1'b1;
    if (op_i == OP_RTYPE) begin
      case (func_i)
        FN_ADD:  alu_cntl_o = ALU_ADD;
        FN_ADDU: alu_cntl_o = ALU_ADDU;
        FN_SUB:  alu_cntl_o = ALU_SUB;
        FN_SUBU: alu_cntl_o = ALU_SUBU;
        FN_AND:  alu_cntl_o = ALU_AND;
        FN_OR:   alu_cntl_o = ALU_OR;
        FN_XOR:  alu_cntl_o = ALU_XOR;
        FN_NOR:  alu_cntl_o = ALU_NOR;
        FN_SLT:  alu_cntl_o = ALU_SLT;
        FN_SLTU: alu_cntl_o = ALU_SLTU;
        default: legal_o    = 1'b0;
      endcase
    end else begin
      case (op_i)
        OP_ADDI:  alu_cntl_o = ALU_ADD;
        OP_ADDIU: alu_cntl_o = ALU_ADDU;
        OP_SLTI:  alu_cntl_o = ALU_SLT;
        OP_SLTIU: alu_cntl_o = ALU_SLTU;
        OP_ANDI:  alu_cntl_o = ALU_AND;
        OP_ORI:   alu_cntl_o = ALU_OR;
        default:  legal_o    = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM with memory ready handshake, timeout and trap.
// Define MC_JUMP_EN to add the j instruction (JUMP state, PCSrc jump target).
module multicycle_control
  import mc_control_pkg::*;
#(
  parameter int unsigned ALUC_W      = 4,
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned TO_W        = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [5:0]        Op,
  input  logic [5:0]        Func,
  input  logic              mem_ready,
  output logic              PCWrite,
  output logic [1:0]        Branch,
  output logic              IorD,
  output logic              MemRead,
  output logic              MemWrite,
  output logic              IRWrite,
  output logic              MemtoReg,
  output logic              RegDst,
  output logic              RegWrite,
  output logic              ALUSrcA,
  output logic [1:0]        ALUSrcB,
  output logic [ALUC_W-1:0] ALUCntl,
  output logic [1:0]        PCSrc,
  output logic              instr_done,
  output logic              illegal_op,
  output logic              bus_err,
  output logic [3:0]        state
);

  state_e          state_q, state_d;
  logic [5:0]      op_q, func_q;
  logic [TO_W-1:0] to_q, to_d;
  logic            illegal_q, bus_err_q;
  logic            set_illegal, set_bus_err;
  logic            mem_wait, timeout_hit;

  logic [5:0] dec_op, dec_func;
  logic [3:0] dec_alu, alu_sel;
  logic       dec_legal;

  // In DECODE the IR fields are live on Op/Func; afterwards use the latched copy.
  assign dec_op   = (state_q == StDecode) ? Op   : op_q;
  assign dec_func = (state_q == StDecode) ? Func : func_q;

  alu_op_decode u_alu_op_decode (
    .op_i       (dec_op),
    .func_i     (dec_func),
    .alu_cntl_o (dec_alu),
    .legal_o    (dec_legal)
  );

  assign mem_wait    = waits_on_mem(state_q) && !mem_ready;
  assign timeout_hit = mem_wait && (to_q == TO_W'(MEM_TIMEOUT - 1));

  always_comb begin
    state_d     = state_q;
    to_d        = mem_wait ? to_q + TO_W'(1) : '0;
    set_bus_err = 1'b0;
    case (state_q)
      StIdle:   state_d = StFetch;
      StFetch:  if (mem_ready) state_d = StDecode;
      StDecode: begin
        case (Op)
          OP_RTYPE: state_d = dec_legal ? StExecR : StTrap;
          OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI: state_d = StExecI;
          OP_LW, OP_SW:   state_d = StAddr;
          OP_BEQ, OP_BNE: state_d = StBranch;
`ifdef MC_JUMP_EN
          OP_J:           state_d = StJump;
`endif
          default:        state_d = StTrap;
        endcase
      end
      StExecR, StExecI: state_d = StWbAlu;
      StAddr:   state_d = (op_q == OP_LW) ? StMemRd : StMemWr;
      StMemRd:  if (mem_ready) state_d = StWbMem;
      StMemWr:  if (mem_ready) state_d = StFetch;
      StWbAlu, StWbMem, StBranch: state_d = StFetch;
`ifdef MC_JUMP_EN
      StJump:   state_d = StFetch;
`endif
      StTrap:   state_d = StTrap;
      default:  state_d = StTrap;
    endcase
    if (timeout_hit) begin
      state_d     = StTrap;
      set_bus_err = 1'b1;
    end
  end

  assign set_illegal = (state_q == StDecode) && (state_d == StTrap);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      op_q      <= '0;
      func_q    <= '0;
      to_q      <= '0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      to_q    <= to_d;
      if (state_q == StDecode) begin
        op_q   <= Op;
        func_q <= Func;
      end
      if (set_illegal) illegal_q <= 1'b1;
      if (set_bus_err) bus_err_q <= 1'b1;
    end
  end

  always_comb begin
    PCWrite    = 1'b0;
    Branch     = BR_NONE;
    IorD       = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    MemtoReg   = 1'b0;
    RegDst     = 1'b0;
    RegWrite   = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = SRCB_RT;
    alu_sel    = ALU_AND;
    PCSrc      = PCSRC_ALU;
    instr_done = 1'b0;
    case (state_q)
      StFetch: begin
        MemRead = 1'b1;
        ALUSrcB = SRCB_FOUR;
        alu_sel = ALU_ADDU;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
      end
      StDecode: begin
        ALUSrcB = SRCB_IMM_SH;
        alu_sel = ALU_ADDU;
      end
      StExecR: begin
        ALUSrcA = 1'b1;
        alu_sel = dec_alu;
      end
      StExecI: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        alu_sel = dec_alu;
      end
      StAddr: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        alu_sel = ALU_ADDU;
      end
      StMemRd: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      StMemWr: begin
        MemWrite   = 1'b1;
        IorD       = 1'b1;
        instr_done = mem_ready;
      end
      StWbAlu: begin
        RegWrite   = 1'b1;
        RegDst     = (op_q == OP_RTYPE);
        instr_done = 1'b1;
      end
      StWbMem: begin
        RegWrite   = 1'b1;
        MemtoReg   = 1'b1;
        instr_done = 1'b1;
      end
      StBranch: begin
        ALUSrcA    = 1'b1;
        alu_sel    = ALU_SUB;
        PCSrc      = PCSRC_ALUOUT;
        Branch     = (op_q == OP_BNE) ? BR_BNE : BR_BEQ;
        instr_done = 1'b1;
      end
`ifdef MC_JUMP_EN
      StJump: begin
        PCWrite    = 1'b1;
        PCSrc      = PCSRC_JUMP;
        instr_done = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  assign ALUCntl    = ALUC_W'(alu_sel);
  assign illegal_op = illegal_q;
  assign bus_err    = bus_err_q;
  assign state      = state_q;

endmodule
